// File: rtl/shift_seq_ctrl.sv
// Two-requester round-robin front end for an iterative one-bit-per-clock 32-bit shifter.
// Optional build macro SHIFT_SEQ_SRA_EN: op 10 sign-fills; otherwise op 10 behaves as SRL.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [SHW-1:0]   req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [SHW-1:0]   req1_shamt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_res,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_op;
  logic             r_id;
  logic             r_last;

  logic             w_any_valid;
  logic             w_grant;
  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_step;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_grant     = (req0_valid & req1_valid) ? ~r_last : ~req0_valid;
    w_accept    = rst_n & (r_state == S_IDLE) & w_any_valid;
    w_op        = w_grant ? req1_op    : req0_op;
    w_a         = w_grant ? req1_a     : req0_a;
    w_shamt     = w_grant ? req1_shamt : req0_shamt;
  end

  assign req0_ready = w_accept & ~w_grant;
  assign req1_ready = w_accept &  w_grant;

  always_comb begin
    w_step = r_data;
    case (op_t'(r_op))
      OP_SLL: w_step = {r_data[WIDTH-2:0], 1'b0};
      OP_SRL: w_step = {1'b0, r_data[WIDTH-1:1]};
`ifdef SHIFT_SEQ_SRA_EN
      OP_SRA: w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
`else
      OP_SRA: w_step = {1'b0, r_data[WIDTH-1:1]};
`endif
      OP_ROR: w_step = {r_data[0], r_data[WIDTH-1:1]};
      default: w_step = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data  <= w_a;
            r_cnt   <= w_shamt;
            r_op    <= w_op;
            r_id    <= w_grant;
            r_last  <= w_grant;
            r_state <= (w_shamt != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          r_data <= w_step;
          r_cnt  <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == S_DONE);
  assign rsp_res   = r_data;
  assign rsp_id    = r_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: vector table plus arbitration, back-pressure and reset sequences.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_a;
  logic [4:0]  req0_shamt;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_a;
  logic [4:0]  req1_shamt;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_res;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  shift_seq_ctrl #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [4:0] s);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_shamt = s;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_shamt = s;
    end
  endtask

  task automatic wait_ready(input logic id);
    int c = 0;
    while (!(id ? req1_ready : req0_ready) && c < 60) begin
      @(negedge clk); #1; c++;
    end
    check("ready_seen", 32'(c < 60), 32'd1);
    check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk); lat++;
    end
    check("rsp_seen", 32'(lat < 100), 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("busy_fall", 32'(busy), 32'd0);
    check("rsp_valid_fall", 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clk);
    set_req(v.id, 1'b1, v.op, v.a, v.shamt);
    #1;
    wait_ready(v.id);
    @(negedge clk);
    set_req(v.id, 1'b0, 2'b00, 32'h0, 5'd0);
    check("busy_rise", 32'(busy), 32'd1);
    wait_rsp(lat);
    check("latency", 32'(lat), 32'(v.shamt));
    check("rsp_res", rsp_res, v.exp);
    check("rsp_id", 32'(rsp_id), 32'(v.id));
    handshake();
  endtask

  // Both requesters hold SRL-by-1 requests; grants must alternate starting with requester 0.
  task automatic tie_seq(input int n);
    int lat;
    logic exp_id;
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b01, 32'h0000_0010, 5'd1);
    set_req(1'b1, 1'b1, 2'b01, 32'h0000_0100, 5'd1);
    #1;
    for (int i = 0; i < n; i++) begin
      exp_id = 1'(i % 2);
      wait_ready(exp_id);
      check("tie_grant", 32'(req1_ready), 32'(exp_id));
      @(negedge clk);
      check("tie_ready_shift", 32'({req0_ready, req1_ready}), 32'd0);
      wait_rsp(lat);
      check("tie_latency", 32'(lat), 32'd1);
      check("tie_ready_done", 32'({req0_ready, req1_ready}), 32'd0);
      check("tie_id", 32'(rsp_id), 32'(exp_id));
      check("tie_res", rsp_res, exp_id ? 32'h0000_0080 : 32'h0000_0008);
      handshake();
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    int lat, stray;
    vecs[0]  = '{1'b0, 2'b01, 32'hFFFF_0000, 5'd3,  32'h1FFF_E000};
    vecs[1]  = '{1'b1, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[2]  = '{1'b0, 2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678};
`ifdef SHIFT_SEQ_SRA_EN
    vecs[3]  = '{1'b0, 2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[10] = '{1'b1, 2'b10, 32'hA5A5_A5A5, 5'd8,  32'hFFA5_A5A5};
`else
    vecs[3]  = '{1'b0, 2'b10, 32'h8000_0000, 5'd4,  32'h0800_0000};
    vecs[10] = '{1'b1, 2'b10, 32'hA5A5_A5A5, 5'd8,  32'h00A5_A5A5};
`endif
    vecs[4]  = '{1'b1, 2'b11, 32'h0000_000F, 5'd4,  32'hF000_0000};
    vecs[5]  = '{1'b0, 2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[6]  = '{1'b1, 2'b10, 32'h7FFF_FFFF, 5'd1,  32'h3FFF_FFFF};
    vecs[7]  = '{1'b0, 2'b01, 32'h8000_0001, 5'd31, 32'h0000_0001};
    vecs[8]  = '{1'b1, 2'b11, 32'h8000_0001, 5'd1,  32'hC000_0000};
    vecs[9]  = '{1'b0, 2'b00, 32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500};

    rst_n = 1'b0; rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF, 5'd3);
    set_req(1'b1, 1'b0, 2'b00, 32'h0, 5'd0);
    repeat (3) @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_outs", {rsp_valid, rsp_id, busy, req1_ready}, 32'd0);
    check("rst_res", rsp_res, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    tie_seq(4);

    foreach (vecs[i]) run_op(vecs[i]);

    // Back-pressure: result held for 10 cycles while requester 0 waits.
    run_op('{1'b0, 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C});
    @(negedge clk);
    set_req(1'b1, 1'b1, 2'b01, 32'h0000_00F0, 5'd2);
    #1;
    wait_ready(1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(lat);
    set_req(1'b0, 1'b1, 2'b00, 32'h0000_0005, 5'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_res", rsp_res, 32'h0000_003C);
      check("hold_id", 32'(rsp_id), 32'd1);
      check("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    handshake();
    #1;
    wait_ready(1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(lat);
    check("after_hold_lat", 32'(lat), 32'd0);
    check("after_hold_res", rsp_res, 32'h0000_0005);
    check("after_hold_id", 32'(rsp_id), 32'd0);
    handshake();

    // Reset mid-shift; last served was requester 0, so only reset can make 0 win the next tie.
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b00, 32'h0000_0001, 5'd20);
    #1;
    wait_ready(1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req1_valid = 1'b1;
    #1;
    check("mid_rst_outs", {rsp_valid, rsp_id, busy, req0_ready, req1_ready}, 32'd0);
    check("mid_rst_res", rsp_res, 32'd0);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) stray++;
    end
    check("no_stray_rsp", 32'(stray), 32'd0);
    tie_seq(2);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle shift sequencer and two-port arbiter for the shared 32-bit shift datapath. It accepts shift requests from two requesters over valid/ready handshakes and arbitrates between them round-robin. The accepted operand is shifted one bit position per clock, and the result is returned on a single response channel tagged with the requester id. It sits between the ALU/instruction-sequencing logic and the shifter resource, so that one small iterative shifter serves both clients.

## Interface
Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.
- SHW, 5, shift-amount width, equal to log2(WIDTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a pending operation.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- req0_a  in  32  operand.
- req0_shamt  in  5  shift amount, 0..31.
- req1_valid / req1_ready / req1_op / req1_a / req1_shamt: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that issued the operation.
- rsp_res  out  32  shifted result.
- busy  out  1  high whenever state is not IDLE.

## Operation
States:
- IDLE: waiting for a request; no operation held.
- SHIFT: operand is being shifted; cnt holds the remaining shift count.
- DONE: result held on the response channel.

IDLE:
- Grant logic is combinational.
- With one requester valid, that requester is granted.
- With both valid, the requester not served last is granted. The last-served register resets to 1, so requester 0 wins the first tie.
- reqN_ready = (state==IDLE) & grant==N. Only one ready is ever high.
- A requester holds valid and its payload stable until its ready is seen.

Accept (valid & ready at an edge):
- Latch data=a, cnt=shamt, op, id=N, last=N.
- Next state is SHIFT if shamt≠0, otherwise DONE.

SHIFT, on each edge:
- data is updated by one position:
  - SLL: {data[30:0],0}
  - SRL: {0,data[31:1]}
  - SRA: {data[31],data[31:1]}
  - ROR: {data[0],data[31:1]}
- cnt decrements.
- When cnt reaches 0, go to DONE.

DONE:
- rsp_valid=1; rsp_res=data and rsp_id=id, both stable.
- On rsp_ready, return to IDLE.
- No new request is accepted in the DONE cycle.

Arithmetic:
- Shift amounts are 0..31; there is no wrap case.
- ROR by 0 returns the operand unchanged.

Reset (rst_n low, at any time including mid-SHIFT or in DONE):
- state=IDLE; the pending operation is discarded with no response.
- Registers cleared: data=0, cnt=0, id=0, last=1.
- Outputs: rsp_valid=0, rsp_res=0, rsp_id=0, busy=0, req0_ready=0, req1_ready=0.
- Ready outputs are 0 while rst_n is low.

## Timing
- Acceptance at edge k with shamt=s: the state enters DONE at edge k+s, and rsp_valid is high from the cycle after edge k+s.
- For s=0, rsp_valid is high in the cycle right after acceptance.
- Response handshake at edge j gives state=IDLE after edge j. The earliest next acceptance is edge j+1.
- Peak throughput is one operation per s+2 cycles.
- busy rises after the acceptance edge and falls after the response-handshake edge.
- A requester whose valid drops before ready has no effect; dropping valid early is a protocol violation on the requester side.
- rsp_valid never deasserts without rsp_ready, except on reset.
- Simultaneous rsp_ready and new request valid in DONE: only the response completes. The request is accepted the next cycle.

## Configuration
- SHIFT_SEQ_SRA_EN defined: op 10 performs an arithmetic right shift (sign replication).
- Not defined: op 10 is executed exactly as SRL (zero fill), and the sign-replication logic is absent.
- All other behaviour and timing are identical in both builds.

## Test plan
- Reset, then req0: op=01, a=0xFFFF0000, shamt=3, accepted at edge k. Required: rsp_valid after edge k+3, rsp_res=0x1FFFE000, rsp_id=0; busy falls after the rsp_ready edge.
- req1: SLL, a=0x00000001, shamt=31. Required: rsp_res=0x80000000 with rsp_id=1, 31 cycles after acceptance. Also, shamt=0 with a=0x12345678 returns 0x12345678 one cycle after acceptance.
- req0: op=10, a=0x80000000, shamt=4. With SHIFT_SEQ_SRA_EN: rsp_res=0xF8000000. Without it: 0x08000000. Also ROR a=0x0000000F by 4 returns 0xF0000000.
- Both valid right after reset, each with SRL by 1 and distinct operands. Required: req0 served first (rsp_id=0), then req1 (rsp_id=1), with exactly one readyN per acceptance. Holding both valid repeatedly must alternate ids 0,1,0,1.
- Hold rsp_ready=0 for 10 cycles in DONE. Required: rsp_valid, rsp_res and rsp_id stay stable, and reqN_ready stays 0 throughout.
- Assert rst_n low mid-SHIFT (SLL, shamt=20, after 5 shift cycles). Required: all outputs are 0 immediately, no response is issued, and the next request after reset behaves as if first.
